// File: rtl/srff_cmd_driver.sv
// srff_cmd_driver: sequences SET/CLR/PRESET/HOLD commands into timed, mutually
// exclusive S/R or active-low preset pulses and confirms the result on Q.
module srff_cmd_driver #(
    parameter int PULSE_W = 1,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       Q,
    output logic       S,
    output logic       R,
    output logic       P,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // state    | meaning
    // ---------+--------------------------------------------------------------
    // ST_IDLE  | ready for a command; HOLD is answered here without leaving
    // ST_PULSE | S, R or P held active for PULSE_W cycles
    // ST_CHECK | drives released, Q compared to the expected value, TIMEOUT max
    // ST_GAP   | GAP_W guard cycles with all drives inactive

    localparam int MAX_A = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_W = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_PRESET = 2'b11;

    generate
        if (PULSE_W < 1) begin : g_bad_pulse_w
            $error("srff_cmd_driver: PULSE_W must be at least 1");
        end
        if (GAP_W < 0) begin : g_bad_gap_w
            $error("srff_cmd_driver: GAP_W must not be negative");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("srff_cmd_driver: TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             p_q, p_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             q_match;

    assign q_match = (Q == exp_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        // Drives rest inactive unless PULSE explicitly holds them.
        s_d     = 1'b0;
        r_d     = 1'b0;
        p_d     = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_HOLD: begin
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            r_d     = 1'b1;
                            exp_d   = 1'b0;
                            cnt_d   = PULSE_LD;
                            state_d = ST_PULSE;
                        end
                        OP_SET: begin
                            s_d     = 1'b1;
                            exp_d   = 1'b1;
                            cnt_d   = PULSE_LD;
                            state_d = ST_PULSE;
                        end
                        default: begin
                            p_d     = 1'b0;
                            exp_d   = 1'b1;
                            cnt_d   = PULSE_LD;
                            state_d = ST_PULSE;
                        end
                    endcase
                end
            end

            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CHECK_LD;
                    state_d = ST_CHECK;
                end else begin
                    s_d   = s_q;
                    r_d   = r_q;
                    p_d   = p_q;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_CHECK: begin
                if (q_match || (cnt_q == '0)) begin
                    done_d = 1'b1;
                    err_d  = ~q_match;
                    if (GAP_W > 0) begin
                        cnt_d   = GAP_LD;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            p_q     <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            s_q     <= s_d;
            r_q     <= r_d;
            p_q     <= p_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign P         = p_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/srff_cmd_driver.md
# srff_cmd_driver

Command sequencer that sits directly upstream of the team's SR flip-flop stage. It accepts SET / CLR / PRESET / HOLD commands over a valid/ready handshake and converts each into a timed, mutually exclusive S/R pulse or active-low preset pulse. It then watches the flip-flop's Q feedback to confirm the state change, and reports completion with a pass/fail flag. The block guarantees that the illegal S=R=1 combination is never presented downstream.

## Interface
Parameters:
- PULSE_W, default 1: cycles S, R or P is held active per command; legal range ≥1.
- GAP_W, default 1: idle guard cycles (S=R=0, P=1) after each completed pulse command; legal range ≥0.
- TIMEOUT, default 4: maximum CHECK cycles spent waiting for Q to match; legal range ≥1.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_op  in  2  00 HOLD, 01 CLR, 10 SET, 11 PRESET
- cmd_ready  out  1  high only in IDLE
- Q  in  1  feedback from downstream flip-flop
- S  out  1  set drive, registered
- R  out  1  reset drive, registered
- P  out  1  preset drive, active-low, registered
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid only when done=1; 1 = Q did not reach its expected value

## Operation
- FSM states: IDLE, PULSE, CHECK, GAP.
- **Accept:** a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1. cmd_op and the expected Q value (SET→1, CLR→0, PRESET→1) are latched at that edge. cmd_valid while busy is ignored and is not queued.
- **IDLE → PULSE** on accepting SET, CLR or PRESET.
  - SET drives S=1, R=0, P=1.
  - CLR drives S=0, R=1, P=1.
  - PRESET drives S=0, R=0, P=0.
- **IDLE, HOLD accepted:** no pulse is issued. done=1, err=0 are driven the next cycle. The FSM stays IDLE and cmd_ready stays high.
- **PULSE:** the drive is held for PULSE_W cycles. The block then enters CHECK with S=R=0, P=1.
- **CHECK:** Q is compared against the expected value each cycle.
  - On a match, done=1 and err=0 are driven, and the FSM moves to GAP (or straight to IDLE when GAP_W=0).
  - After TIMEOUT cycles without a match, done=1 and err=1 are driven, with the same transition.
- **GAP:** GAP_W cycles with S=R=0, P=1, then IDLE.
- **Invariants, every cycle:**
  - never S=R=1;
  - P=0 only when S=R=0;
  - S/R/P are active only in PULSE.
- **Counter:** one down-counter of width $clog2(max(PULSE_W,GAP_W,TIMEOUT)+1), reloaded on each state entry. No wrap: it saturates at 0.

## Timing
- **Reset values** (while rst=0, applied asynchronously): S=0, R=0, P=1, busy=0, done=0, err=0, cmd_ready=1, state IDLE, counter 0.
- **Reset mid-operation:** drives drop immediately to their reset values. No done pulse is emitted for the aborted command.
- **Latency:** accept at edge k puts the pulse on the outputs from edge k through edge k+PULSE_W.
  - With a downstream flip-flop updating on the first pulse edge, Q matches in the first CHECK cycle.
  - Result: done is high in the cycle after edge k+PULSE_W+1 (PULSE_W=1 → 3 cycles after the accept cycle).
- **Ready:** cmd_ready rises again GAP_W cycles after the done cycle. With GAP_W=0, cmd_ready is high in the same cycle as done.
- **Back-to-back throughput:** 1 + PULSE_W + 1 + GAP_W cycles per pulse command on a matched loop.
- **Already-in-state commands:** SET while Q=1 still issues the full pulse and passes in CHECK.
- **Simultaneous events:** a command presented in the done cycle with GAP_W=0 is accepted on that edge.

## Test plan
- **Reset:** rst=0 mid-SET pulse → S drops to 0 asynchronously, P=1, busy=0, no done; after release, cmd_ready=1.
- **SET/CLR loopback:** PULSE_W=1, GAP_W=1, driver looped to an SR flip-flop model. SET at cycle 0 → S=1 for exactly 1 cycle, done=1/err=0 at cycle 3, cmd_ready=1 at cycle 4. Then CLR → R=1 for 1 cycle, Q=0, done/err=0.
- **PRESET:** PULSE_W=3 → P=0 for 3 cycles with S=R=0, Q=1, done/err=0 on the first CHECK cycle.
- **Timeout:** Q stuck at 0 with SET, TIMEOUT=4 → exactly 4 CHECK cycles, then done=1, err=1; S never re-asserted.
- **Handshake:**
  - cmd_valid held high through a SET → only one accept; commands while busy=1 are dropped.
  - HOLD → done=1 next cycle, busy stays 0.
- **Randomized stream:** 1000 random ops with random cmd_valid → assertion that S&R is never 1 and P=0 only when S=R=0; every accepted pulse op yields exactly one done.
